// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU and result-select encodings, immediate formats.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } aluOp_t;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J,
    IMM_U
  } immFmt_t;

  // isReg distinguishes add/sub (R-type only) from addi, which has no sub form.
  function automatic aluOp_t aluFromFunct3(input logic [2:0] f3, input logic bit30,
                                           input logic isReg);
    aluOp_t op;
    case (f3)
      3'b000:  op = (isReg && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] immGen(input logic [31:0] instr, input immFmt_t fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 register file, two combinational read ports, one write port at posedge; x0 reads zero.
// Build option REGFILE_BYPASS_EN: a same-cycle write is forwarded to the read ports.
module regfile_2r1w
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && wa != 5'd0) begin
      mem[wa] <= wd;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign rd1 = (ra1 == 5'd0) ? '0 : (we && wa == ra1) ? wd : mem[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : (we && wa == ra2) ? wd : mem[ra2];
`else
  assign rd1 = (ra1 == 5'd0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : mem[ra2];
`endif

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: control decode, immediate generation, register read, ID/EX pipeline register.
// Build option REGFILE_BYPASS_EN enables WB->ID write-before-read in the register file.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            bubble,
  input  logic [31:0]     instrD,
  input  logic [XLEN-1:0] PCD,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic            JalrE,
  output logic            ALUSrcAE,
  output logic            ALUSrcBE,
  output logic [3:0]      ALUControlE,
  output logic [2:0]      funct3E,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            IllegalE
);

  logic        regWriteD, memWriteD, branchD, jumpD, jalrD, aluSrcAD, aluSrcBD;
  logic        useRs1, useRs2, legalD, illegalD;
  logic [1:0]  resultSrcD;
  aluOp_t      aluCtlD;
  immFmt_t     immFmt;
  logic [4:0]  rs1Eff, rs2Eff, rdEff;
  logic [2:0]  funct3D;
  logic [31:0] immD;
  logic [XLEN-1:0] rd1D, rd2D;

  assign Rs1D = instrD[19:15];
  assign Rs2D = instrD[24:20];

  always_comb begin
    regWriteD  = 1'b0;
    resultSrcD = RES_ALU;
    memWriteD  = 1'b0;
    branchD    = 1'b0;
    jumpD      = 1'b0;
    jalrD      = 1'b0;
    aluSrcAD   = 1'b0;
    aluSrcBD   = 1'b0;
    aluCtlD    = ALU_ADD;
    immFmt     = IMM_NONE;
    useRs1     = 1'b0;
    useRs2     = 1'b0;
    legalD     = 1'b1;
    illegalD   = 1'b0;
    case (instrD[6:0])
      OP_R: begin
        regWriteD = 1'b1;
        useRs1    = 1'b1;
        useRs2    = 1'b1;
        aluCtlD   = aluFromFunct3(instrD[14:12], instrD[30], 1'b1);
      end
      OP_I: begin
        regWriteD = 1'b1;
        useRs1    = 1'b1;
        aluSrcBD  = 1'b1;
        immFmt    = IMM_I;
        aluCtlD   = aluFromFunct3(instrD[14:12], instrD[30], 1'b0);
      end
      OP_LOAD: begin
        regWriteD  = 1'b1;
        resultSrcD = RES_MEM;
        useRs1     = 1'b1;
        aluSrcBD   = 1'b1;
        immFmt     = IMM_I;
      end
      OP_STORE: begin
        memWriteD = 1'b1;
        useRs1    = 1'b1;
        useRs2    = 1'b1;
        aluSrcBD  = 1'b1;
        immFmt    = IMM_S;
      end
      OP_BRANCH: begin
        branchD = 1'b1;
        useRs1  = 1'b1;
        useRs2  = 1'b1;
        aluCtlD = ALU_SUB;
        immFmt  = IMM_B;
      end
      OP_JAL: begin
        jumpD      = 1'b1;
        regWriteD  = 1'b1;
        resultSrcD = RES_PC4;
        immFmt     = IMM_J;
      end
      OP_JALR: begin
        jumpD      = 1'b1;
        jalrD      = 1'b1;
        regWriteD  = 1'b1;
        resultSrcD = RES_PC4;
        useRs1     = 1'b1;
        aluSrcBD   = 1'b1;
        immFmt     = IMM_I;
      end
      OP_LUI: begin
        regWriteD = 1'b1;
        aluSrcBD  = 1'b1;
        aluCtlD   = ALU_PASSB;
        immFmt    = IMM_U;
      end
      OP_AUIPC: begin
        regWriteD = 1'b1;
        aluSrcAD  = 1'b1;
        aluSrcBD  = 1'b1;
        immFmt    = IMM_U;
      end
      default: begin
        legalD   = 1'b0;
        illegalD = (instrD != 32'd0);
      end
    endcase
  end

  // Unused index fields are zeroed so the hazard unit never forwards on immediate bits.
  assign rs1Eff  = useRs1 ? instrD[19:15] : 5'd0;
  assign rs2Eff  = useRs2 ? instrD[24:20] : 5'd0;
  assign rdEff   = regWriteD ? instrD[11:7] : 5'd0;
  assign funct3D = legalD ? instrD[14:12] : 3'd0;
  assign immD    = immGen(instrD, immFmt);

  regfile_2r1w #(.XLEN(XLEN), .NREG(NREG)) uRegfile (
    .clk (clk),
    .rst (rst),
    .we  (RegWriteW),
    .wa  (RdW),
    .wd  (ResultW),
    .ra1 (rs1Eff),
    .ra2 (rs2Eff),
    .rd1 (rd1D),
    .rd2 (rd2D)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush || bubble) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= '0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      JalrE       <= 1'b0;
      ALUSrcAE    <= 1'b0;
      ALUSrcBE    <= 1'b0;
      ALUControlE <= '0;
      funct3E     <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      IllegalE    <= 1'b0;
    end else begin
      RegWriteE   <= regWriteD;
      ResultSrcE  <= resultSrcD;
      MemWriteE   <= memWriteD;
      BranchE     <= branchD;
      JumpE       <= jumpD;
      JalrE       <= jalrD;
      ALUSrcAE    <= aluSrcAD;
      ALUSrcBE    <= aluSrcBD;
      ALUControlE <= aluCtlD;
      funct3E     <= funct3D;
      RD1E        <= rd1D;
      RD2E        <= rd2D;
      ImmExtE     <= immD;
      PCE         <= PCD;
      Rs1E        <= rs1Eff;
      Rs2E        <= rs2Eff;
      RdE         <= rdEff;
      IllegalE    <= illegalD;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed cases then random instruction mix against a reference model.
module tb_decode_stage;

  logic        clk, rst, flush, bubble;
  logic [31:0] instrD, PCD, ResultW;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcAE, ALUSrcBE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .bubble(bubble),
    .instrD(instrD), .PCD(PCD),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE),
    .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .ALUControlE(ALUControlE),
    .funct3E(funct3E), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .IllegalE(IllegalE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [159:0] got;
  assign got = {RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcAE, ALUSrcBE,
                ALUControlE, funct3E, RD1E, RD2E, ImmExtE, PCE, Rs1E, Rs2E, RdE, IllegalE};

  typedef struct {
    string        name;
    logic [159:0] v;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] regs [32];

  // Architectural register read as seen by an instruction decoded during a WB write.
  function automatic logic [31:0] rdReg(input logic [4:0] idx, input logic we,
                                        input logic [4:0] wrd, input logic [31:0] wres);
    if (idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && wrd == idx) return wres;
`endif
    return regs[idx];
  endfunction

  function automatic logic [159:0] model(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic fl, input logic bu, input logic we,
                                         input logic [4:0] wrd, input logic [31:0] wres);
    logic [3:0]  opTab [8];
    logic [31:0] sx, immI, immS, immB, immJ, immU, imm;
    logic        rw, mw, br, jp, jr, sa, sb, u1, u2, ill, legal;
    logic [1:0]  rsrc;
    logic [3:0]  alu;
    logic [2:0]  f3, fn3;
    logic [4:0]  r1, r2, rd;
    opTab = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    if (fl || bu) return 160'd0;
    f3   = ins[14:12];
    sx   = ins[31] ? 32'hFFFF_FFFF : 32'd0;
    immI = (sx << 12) | 32'(ins[31:20]);
    immS = (sx << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
    immB = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    immJ = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    immU = ins & 32'hFFFF_F000;
    {rw, mw, br, jp, jr, sa, sb, u1, u2, ill} = 10'd0;
    legal = 1'b1; rsrc = 2'd0; alu = 4'd0; imm = 32'd0;
    case (ins[6:0])
      7'h33: begin
        rw = 1; u1 = 1; u2 = 1; alu = opTab[f3];
        if (f3 == 3'd0 && ins[30]) alu = 4'd1;
        if (f3 == 3'd5 && ins[30]) alu = 4'd7;
      end
      7'h13: begin
        rw = 1; u1 = 1; sb = 1; imm = immI; alu = opTab[f3];
        if (f3 == 3'd5 && ins[30]) alu = 4'd7;
      end
      7'h03: begin rw = 1; rsrc = 2'd1; u1 = 1; sb = 1; imm = immI; end
      7'h23: begin mw = 1; u1 = 1; u2 = 1; sb = 1; imm = immS; end
      7'h63: begin br = 1; u1 = 1; u2 = 1; alu = 4'd1; imm = immB; end
      7'h6F: begin jp = 1; rw = 1; rsrc = 2'd2; imm = immJ; end
      7'h67: begin jp = 1; jr = 1; rw = 1; rsrc = 2'd2; u1 = 1; sb = 1; imm = immI; end
      7'h37: begin rw = 1; sb = 1; alu = 4'd10; imm = immU; end
      7'h17: begin rw = 1; sa = 1; sb = 1; imm = immU; end
      default: begin legal = 0; ill = (ins != 32'd0); end
    endcase
    fn3 = legal ? f3 : 3'd0;
    r1  = u1 ? ins[19:15] : 5'd0;
    r2  = u2 ? ins[24:20] : 5'd0;
    rd  = rw ? ins[11:7] : 5'd0;
    return {rw, rsrc, mw, br, jp, jr, sa, sb, alu, fn3,
            rdReg(r1, we, wrd, wres), rdReg(r2, we, wrd, wres), imm, pc, r1, r2, rd, ill};
  endfunction

  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                      input logic bu, input logic we, input logic [4:0] wrd,
                      input logic [31:0] wres, input string nm);
    exp_t e;
    @(negedge clk);
    instrD = ins; PCD = pc; flush = fl; bubble = bu;
    RegWriteW = we; RdW = wrd; ResultW = wres;
    e.name = nm;
    e.v = model(ins, pc, fl, bu, we, wrd, wres);
    sbq.push_back(e);
    if (we && wrd != 5'd0) regs[wrd] = wres;
  endtask

  task automatic checkZero(input string nm);
    total++;
    if (got !== 160'd0) begin
      bad++;
      $display("FAIL %s: outputs=%h required=0", nm, got);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && sbq.size() > 0) begin
      e = sbq.pop_front();
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s: got=%h exp=%h", e.name, got, e.v);
      end
    end
  end

  logic [6:0] ops [10];

  initial begin
    logic [31:0] r, ins;
    int          k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    rst = 1'b1; flush = 0; bubble = 0; instrD = 32'h0050_0093; PCD = 0;
    RegWriteW = 0; RdW = 0; ResultW = 0;
    #1 checkZero("reset_initial");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    step(32'h0050_0093, 32'h8, 0, 0, 0, 5'd0, 32'd0, "addi_x1_5");
    step(32'hFE20_8CE3, 32'hC, 0, 0, 1, 5'd2, 32'h77, "beq_x1_x2_m8");
    step(32'h0031_8233, 32'h10, 0, 0, 1, 5'd3, 32'hDEAD_BEEF, "add_x4_x3_wb_same");
    step(32'h0031_8233, 32'h14, 0, 0, 0, 5'd0, 32'd0, "add_x4_x3_after");
    step(32'h0031_8233, 32'h18, 0, 0, 1, 5'd0, 32'h1234, "write_x0");
    step(32'h0000_02B3, 32'h1C, 0, 0, 0, 5'd0, 32'd0, "add_x5_x0_x0");
    step(32'h0050_0093, 32'h20, 1, 0, 0, 5'd0, 32'd0, "flush");
    step(32'h0050_0093, 32'h24, 0, 1, 0, 5'd0, 32'd0, "bubble");
    step(32'h0050_0093, 32'h28, 1, 1, 0, 5'd0, 32'd0, "flush_bubble");
    step(32'hFFFF_FFFF, 32'h2C, 0, 0, 0, 5'd0, 32'd0, "illegal_ones");
    step(32'h0000_0000, 32'h30, 0, 0, 0, 5'd0, 32'd0, "nop_zero");
    step(32'h4050_D093, 32'h34, 0, 0, 1, 5'd5, 32'h0000_CAFE, "srai_write_x5");
    step(32'h0052_8333, 32'h38, 0, 0, 0, 5'd0, 32'd0, "add_x6_x5_pre_reset");

    @(negedge clk);
    instrD = 32'h0050_0093; PCD = 32'h3C; rst = 1'b1;
    #1 checkZero("reset_midrun");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    step(32'h0052_8333, 32'h40, 0, 0, 0, 5'd0, 32'd0, "x5_after_reset");

    for (int n = 0; n < 500; n++) begin
      r = $urandom();
      k = $urandom_range(0, 11);
      if (k < 10) ins = {r[31:7], ops[k]};
      else if (k == 10) ins = 32'd0;
      else ins = 32'hFFFF_FFFF;
      if (k == 9) ins[6:0] = 7'($urandom());
      step(ins, $urandom(), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           1'($urandom()), 5'($urandom()), $urandom(), $sformatf("rand%0d", n));
    end

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 5-stage RV32I pipeline, directly downstream of fetch.
- Consumes instrD/PCD from the IF/ID register and decodes control.
- Generates the sign-extended immediate and reads the 32x32 register file; the register file is written from WB.
- Registers everything into the ID/EX pipeline register feeding execute; exposes rs1/rs2 combinationally to the hazard unit.

Parameters:
- XLEN, 32, datapath width
- NREG, 32, architectural register count (x0 hardwired zero)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  taken branch/jump in EX; load NOP into ID/EX
- bubble  in  1  load-use stall from hazard unit; load NOP into ID/EX
- instrD  in  32  instruction from fetch (0 = reset/flush NOP)
- PCD  in  32  PC of instrD
- RegWriteW  in  1  WB write enable
- RdW  in  5  WB destination register
- ResultW  in  32  WB write data
- Rs1D  out  5  instrD[19:15], combinational, to hazard unit
- Rs2D  out  5  instrD[24:20], combinational, to hazard unit
- RegWriteE  out  1  EX: writes rd
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- MemWriteE  out  1  store
- BranchE  out  1  conditional branch
- JumpE  out  1  jal/jalr
- JalrE  out  1  target = rs1+imm (else PC+imm)
- ALUSrcAE  out  1  0 rs1, 1 PC (auipc)
- ALUSrcBE  out  1  0 rs2, 1 immediate
- ALUControlE  out  4  ALU op, package encoding
- funct3E  out  3  branch condition / load-store size
- RD1E, RD2E  out  32  register operands
- ImmExtE  out  32  sign-extended immediate
- PCE  out  32  PC of instruction in EX
- Rs1E, Rs2E, RdE  out  5  register indices for forwarding
- IllegalE  out  1  unsupported opcode seen

Behaviour:
- Reset (async): every ID/EX output = 0; all 31 writable registers cleared to 0.
- Latency: instrD presented in cycle N appears on the E outputs after posedge N+1.
- ID/EX update priority at posedge: rst > flush > bubble > load decoded values.
  - flush or bubble (either or both) loads all-zero NOP: every control bit 0, data 0, indices 0.
- Decode coverage:
  - R-type (add/sub/sll/slt/sltu/xor/srl/sra/or/and)
  - I-ALU incl. shifts; srai selected by instr[30]
  - load 0000011, store 0100011, branch 1100011, jal, jalr, lui, auipc
- lui: ALUControl=PASSB, ALUSrcB=1.
- auipc: ALUSrcA=1, ALU ADD.
- jal/jalr: ResultSrc=10, RegWrite=1.
- Any other opcode, including instrD=0:
  - all control 0, IllegalE=1.
  - Exception: instrD==0 is the pipeline NOP and gives IllegalE=0.
- Immediates:
  - I: instr[31:20]
  - S: {instr[31:25],instr[11:7]}
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}
  - I, S, B, J are sign-extended from instr[31].
  - U: {instr[31:12],12'b0}
- Register file:
  - Write at posedge clk when RegWriteW && RdW!=0; writes to x0 are discarded.
  - Reads are combinational; index 0 always reads 0.
- Rs1E/Rs2E are zeroed for formats that do not use them (U, J, and rs2 for I/load), so forwarding does not match spuriously.
- Reset asserted mid-operation discards in-flight contents immediately; no partial state survives.

Optional Feature:
- REGFILE_BYPASS_EN defined:
  - Read of register r where RegWriteW && RdW==r && r!=0 returns ResultW in the same cycle (write-before-read).
  - RD1E/RD2E capture the new value.
- Undefined:
  - Read returns the stored (old) value.
  - The hazard unit owns the WB->ID hazard via stall/forwarding.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants
  - ALU encodings: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASSB 10
  - ResultSrc encodings
  - immediate-format enum
- One sub-module: regfile_2r1w (32x32 array, async reset, bypass under the macro).
- Control decode and immediate generation stay inline.

Test Plan:
- Reset: assert rst mid-run with instrD=0x00500093 -> all E outputs 0 immediately; after release, reads of x5 = 0.
- addi x1,x0,5 (0x00500093), PCD=0x8 -> next edge:
  - RegWriteE=1, RdE=1, ImmExtE=5, ALUControlE=ADD, ALUSrcBE=1, PCE=0x8, Rs2E=0.
- beq x1,x2,-8 (0xFE208CE3) -> BranchE=1, ImmExtE=0xFFFFFFF8, funct3E=0, Rs1E=1, Rs2E=2, RegWriteE=0.
- WB writes x3=0xDEADBEEF while instrD=add x4,x3,x3 (0x00318233):
  - with REGFILE_BYPASS_EN -> RD1E=RD2E=0xDEADBEEF.
  - without -> 0 (previous value); one cycle later either build reads 0xDEADBEEF.
- RegWriteW=1, RdW=0, ResultW=0x1234, then decode add x5,x0,x0 -> RD1E=RD2E=0.
- flush=1 and/or bubble=1 with instrD=0x00500093 -> E outputs all 0 next edge; instrD=0xFFFFFFFF -> IllegalE=1, RegWriteE=MemWriteE=0.
